// File: rtl/if_instr_queue_pkg.sv
// if_instr_queue_pkg: shared fetch/decode queue entry type and the NOP that is
// presented when the queue is empty.
package if_instr_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0340_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        excp;
    } ifq_entry_t;

endpackage

// File: rtl/if_instr_queue.sv
// if_instr_queue: fetch-to-decode decoupling FIFO with flush; the head entry is
// presented straight from registered storage so decode sees a stable word.
module if_instr_queue
    import if_instr_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    input  logic             in_excp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic             out_excp,
    output logic [PTR_W:0]   count
);

    ifq_entry_t       mem [DEPTH];
    ifq_entry_t       head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    // Readiness depends on registered occupancy only; a pop while full frees
    // a slot for the next cycle, not this one.
    always_comb begin
        in_ready  = count != (PTR_W+1)'(DEPTH);
        out_valid = count != '0;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        head      = mem[rd_ptr];
        out_pc    = out_valid ? head.pc : '0;
        out_instr = out_valid ? head.instr : NOP_INSTR;
        out_excp  = out_valid & head.excp;
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr, excp: in_excp};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

endmodule
